// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_pkg
//  Purpose  : Shared types and constants for the data-memory responder.
//  Revision : 1.0 - initial release
// ============================================================================
package dmem_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam int unsigned c_DATA_W     = 64;
    localparam int unsigned c_ADDR_W     = 64;
    localparam logic [2:0]  c_ALIGN_MASK = 3'b111;

endpackage
`default_nettype wire

// File: rtl/dmem_if.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_if
//  Purpose  : Request/response bus between the datapath and the data memory.
//  Revision : 1.0 - initial release
// ============================================================================
interface dmem_if
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W = c_ADDR_W,
    parameter int unsigned DATA_W = c_DATA_W
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              busy;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );

endinterface
`default_nettype wire

// File: rtl/dmem_storage.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_storage
//  Purpose  : DEPTH x DATA_W word array, async clear, sync write, comb read.
//  Revision : 1.0 - initial release
// ============================================================================
module dmem_storage #(
    parameter int unsigned DEPTH  = 128,
    parameter int unsigned DATA_W = 64,
    parameter int unsigned IDX_W  = $clog2(DEPTH)
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              we_i,
    input  wire logic [IDX_W-1:0]  idx_i,
    input  wire logic [DATA_W-1:0] wdata_i,
    output logic      [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[idx_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[idx_i];

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_responder
//  Purpose  : Multi-cycle data-memory responder with WAIT_CYC wait states.
//  Revision : 1.0 - initial release
// ============================================================================
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH    = 128,
    parameter int unsigned ADDR_W   = c_ADDR_W,
    parameter int unsigned DATA_W   = c_DATA_W,
    parameter int unsigned WAIT_CYC = 2
) (
    input  wire logic clk,
    input  wire logic rst,
    dmem_if.slave     bus
);

    localparam int unsigned IDX_W  = $clog2(DEPTH);
    localparam logic [3:0]  c_WAIT = 4'(WAIT_CYC);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              write_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;

    logic              w_accept;
    logic              w_commit;
    logic              w_op_write;
    logic [ADDR_W-1:0] w_op_addr;
    logic [DATA_W-1:0] w_op_wdata;
    logic              w_err;
    logic [DATA_W-1:0] w_mem_rdata;

    assign w_accept = (state_q == S_IDLE) && bus.req_valid;

    // With zero wait states the commit happens on the accept edge, so the
    // operands come straight from the bus while idle and from the latch otherwise.
    assign w_op_write = (state_q == S_IDLE) ? bus.req_write : write_q;
    assign w_op_addr  = (state_q == S_IDLE) ? bus.req_addr  : addr_q;
    assign w_op_wdata = (state_q == S_IDLE) ? bus.req_wdata : wdata_q;

    assign w_err = ((w_op_addr[2:0] & c_ALIGN_MASK) != 3'b000)
                 || (|w_op_addr[ADDR_W-1:IDX_W+3]);

    dmem_storage #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_storage (
        .clk     (clk),
        .rst     (rst),
        .we_i    (w_commit && w_op_write && !w_err),
        .idx_i   (w_op_addr[IDX_W+2:3]),
        .wdata_i (w_op_wdata),
        .rdata_o (w_mem_rdata)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        w_commit = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    cnt_d = c_WAIT;
                    if (WAIT_CYC == 0) begin
                        w_commit = 1'b1;
                        state_d  = S_RESP;
                    end else begin
                        state_d  = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    w_commit = 1'b1;
                    state_d  = S_RESP;
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (w_accept) begin
                write_q <= bus.req_write;
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
            end
            if (w_commit) begin
                rdata_q <= (!w_op_write && !w_err) ? w_mem_rdata : '0;
                err_q   <= w_err;
            end
        end
    end

    assign bus.req_ready = (state_q == S_IDLE);
    assign bus.rsp_valid = (state_q == S_RESP);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;

endmodule
`default_nettype wire
